spi_display_receiver: RTL

Receive-side model of the 4-wire display SPI link (CS, DC, MOSI, SCLK) driven by our line/shape drawing sequencers. It deserialises bytes, decodes the column-address, page-address and memory-write command subset of the panel controller, and emits one pixel-write strobe per RGB565 pixel with its (x, y) address. It sits between the SPI pins (or a drawing sequencer in loopback) and a framebuffer or scoreboard, giving on-chip and in-bench checking of what was drawn.

---
 rtl/spi_display_pkg.sv | 21 ++
 rtl/spi_byte_deserializer.sv | 87 ++++++++
 rtl/spi_display_receiver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/spi_display_pkg.sv
// Shared constants and decoder state encoding for the display SPI receive path.
package spi_display_pkg;

    localparam int COORD_W    = 9;
    localparam int PIX_W      = 16;
    localparam int DEF_WIDTH  = 240;
    localparam int DEF_HEIGHT = 320;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CASET  = 3'd1,
        ST_PASET  = 3'd2,
        ST_RAMWR  = 3'd3,
        ST_IGNORE = 3'd4
    } dec_state_e;

endpackage

// File: rtl/spi_byte_deserializer.sv
// Synchronises the SPI pins into i_clk, detects SCLK rises and assembles
// MSB-first bytes tagged with DC; flags bytes cut short by CS going high.
module spi_byte_deserializer (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_cs,
    input  logic       i_dc,
    input  logic       i_mosi,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_byte_dc,
    output logic       o_err
);

    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] cs_sync_q, cs_sync_d;
    logic [1:0] dc_sync_q, dc_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_q, byte_d;
    logic       byte_dc_q, byte_dc_d;
    logic       err_q, err_d;
    logic       sclk_rise;

    // Stage 2 vs stage 3 keeps MOSI/DC (two stages) aligned with the edge.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];

    always_comb begin
        sclk_sync_d  = {sclk_sync_q[1:0], i_sclk};
        cs_sync_d    = {cs_sync_q[0], i_cs};
        dc_sync_d    = {dc_sync_q[0], i_dc};
        mosi_sync_d  = {mosi_sync_q[0], i_mosi};
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        byte_dc_d    = byte_dc_q;
        err_d        = 1'b0;
        if (cs_sync_q[1]) begin
            bit_cnt_d = 3'd0;
            err_d     = (bit_cnt_q != 3'd0);
        end else if (sclk_rise) begin
            shift_d   = {shift_q[5:0], mosi_sync_q[1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_valid_d = 1'b1;
                byte_d       = {shift_q, mosi_sync_q[1]};
                byte_dc_d    = dc_sync_q[1];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_sync_q  <= 3'b000;
            cs_sync_q    <= 2'b11;
            dc_sync_q    <= 2'b00;
            mosi_sync_q  <= 2'b00;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'd0;
            byte_dc_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            sclk_sync_q  <= sclk_sync_d;
            cs_sync_q    <= cs_sync_d;
            dc_sync_q    <= dc_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_q       <= byte_d;
            byte_dc_q    <= byte_dc_d;
            err_q        <= err_d;
        end
    end

    assign o_byte_valid = byte_valid_q;
    assign o_byte       = byte_q;
    assign o_byte_dc    = byte_dc_q;
    assign o_err        = err_q;

endmodule

// File: rtl/spi_display_receiver.sv
// Decodes CASET/PASET/RAMWR from the deserialised SPI byte stream and emits
// one addressed RGB565 pixel strobe per pair of RAMWR data bytes.
module spi_display_receiver
    import spi_display_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sclk,
    input  logic               i_cs,
    input  logic               i_dc,
    input  logic               i_mosi,
    output logic               o_cmd_valid,
    output logic [7:0]         o_cmd,
    output logic               o_px_valid,
    output logic [COORD_W-1:0] o_px_x,
    output logic [COORD_W-1:0] o_px_y,
    output logic [PIX_W-1:0]   o_px_data,
    output logic               o_err,
    output logic [2:0]         o_dbg_state
);

    localparam logic [COORD_W-1:0] COL_END_RST  = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] PAGE_END_RST = COORD_W'(HEIGHT - 1);

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;
    logic       byte_err;

    spi_byte_deserializer u_deser (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_sclk       (i_sclk),
        .i_cs         (i_cs),
        .i_dc         (i_dc),
        .i_mosi       (i_mosi),
        .o_byte_valid (byte_valid),
        .o_byte       (byte_data),
        .o_byte_dc    (byte_dc),
        .o_err        (byte_err)
    );

    dec_state_e         state_q, state_d;
    logic [1:0]         arg_idx_q, arg_idx_d;
    logic [16:0]        arg_buf_q, arg_buf_d;
    logic [COORD_W-1:0] col_start_q, col_start_d, col_end_q, col_end_d;
    logic [COORD_W-1:0] page_start_q, page_start_d, page_end_q, page_end_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               pend_q, pend_d;
    logic [7:0]         pend_byte_q, pend_byte_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [7:0]         cmd_q, cmd_d;
    logic               px_valid_q, px_valid_d;
    logic [COORD_W-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
    logic [PIX_W-1:0]   px_data_q, px_data_d;
    logic               err_q, err_d;

    // All strobes are single-cycle pulses with no back-pressure: a consumer
    // must take o_cmd / o_px_* in the cycle the matching valid is high.
    always_comb begin
        state_d      = state_q;
        arg_idx_d    = arg_idx_q;
        arg_buf_d    = arg_buf_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        x_d          = x_q;
        y_d          = y_q;
        pend_d       = pend_q;
        pend_byte_d  = pend_byte_q;
        cmd_valid_d  = 1'b0;
        cmd_d        = cmd_q;
        px_valid_d   = 1'b0;
        px_x_d       = px_x_q;
        px_y_d       = px_y_q;
        px_data_d    = px_data_q;
        err_d        = byte_err;
        if (byte_valid && !byte_dc) begin
            cmd_valid_d = 1'b1;
            cmd_d       = byte_data;
            arg_idx_d   = 2'd0;
            pend_d      = 1'b0;
            case (byte_data)
                CMD_CASET: state_d = ST_CASET;
                CMD_PASET: state_d = ST_PASET;
                CMD_RAMWR: begin
                    x_d = col_start_q;
                    y_d = page_start_q;
                    if (col_start_q > col_end_q || page_start_q > page_end_q) begin
                        err_d   = 1'b1;
                        state_d = ST_IGNORE;
                    end else begin
                        state_d = ST_RAMWR;
                    end
                end
                default: state_d = ST_IGNORE;
            endcase
        end else if (byte_valid) begin
            case (state_q)
                ST_CASET, ST_PASET: begin
                    // Buffer keeps {start[8:0], end[8]} so only 9-bit values survive.
                    arg_buf_d = {arg_buf_q[8:0], byte_data};
                    arg_idx_d = arg_idx_q + 2'd1;
                    if (arg_idx_q == 2'd3) begin
                        state_d = ST_IGNORE;
                        if (state_q == ST_CASET) begin
                            col_start_d = arg_buf_q[16:8];
                            col_end_d   = {arg_buf_q[0], byte_data};
                        end else begin
                            page_start_d = arg_buf_q[16:8];
                            page_end_d   = {arg_buf_q[0], byte_data};
                        end
                    end
                end
                ST_RAMWR: begin
                    if (!pend_q) begin
                        pend_d      = 1'b1;
                        pend_byte_d = byte_data;
                    end else begin
                        pend_d     = 1'b0;
                        px_valid_d = 1'b1;
                        px_x_d     = x_q;
                        px_y_d     = y_q;
                        px_data_d  = {pend_byte_q, byte_data};
                        if (x_q == col_end_q) begin
                            x_d = col_start_q;
                            y_d = (y_q == page_end_q) ? page_start_q : y_q + 9'd1;
                        end else begin
                            x_d = x_q + 9'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            arg_idx_q    <= 2'd0;
            arg_buf_q    <= 17'd0;
            col_start_q  <= '0;
            col_end_q    <= COL_END_RST;
            page_start_q <= '0;
            page_end_q   <= PAGE_END_RST;
            x_q          <= '0;
            y_q          <= '0;
            pend_q       <= 1'b0;
            pend_byte_q  <= 8'd0;
            cmd_valid_q  <= 1'b0;
            cmd_q        <= 8'd0;
            px_valid_q   <= 1'b0;
            px_x_q       <= '0;
            px_y_q       <= '0;
            px_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            arg_idx_q    <= arg_idx_d;
            arg_buf_q    <= arg_buf_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            x_q          <= x_d;
            y_q          <= y_d;
            pend_q       <= pend_d;
            pend_byte_q  <= pend_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_q        <= cmd_d;
            px_valid_q   <= px_valid_d;
            px_x_q       <= px_x_d;
            px_y_q       <= px_y_d;
            px_data_q    <= px_data_d;
            err_q        <= err_d;
        end
    end

    assign o_cmd_valid = cmd_valid_q;
    assign o_cmd       = cmd_q;
    assign o_px_valid  = px_valid_q;
    assign o_px_x      = px_x_q;
    assign o_px_y      = px_y_q;
    assign o_px_data   = px_data_q;
    assign o_err       = err_q;
    assign o_dbg_state = state_q;

endmodule
